// File: rtl/tone_beep_gen.sv
// Buzzer tone generator: plays note indices as a 50% square wave, with a silent gap before each new note.
// Latency: a music_tone edge sampled at edge n reaches state/beep/playing at edge n+1; no backpressure.
module tone_beep_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_MS   = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clk_1ms,
  input  logic       beep_en,
  input  logic [7:0] music_tone,
  output logic       beep,
  output logic       playing,
  output logic       tone_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam logic [7:0]  TONE_STOP = 8'd22;
  localparam logic [7:0]  TONE_MAX  = 8'd21;
  localparam logic [15:0] GAP_LIM   = 16'(GAP_MS);
  localparam bit          NO_GAP    = (GAP_MS == 0);

  function automatic logic [16:0] half_period(input int freq_hz);
    return 17'(CLK_FREQ / (2 * freq_hz));
  endfunction

  // Entries beyond 21 are never selected; note_idx is forced to 0 for non-notes.
  localparam logic [16:0] HP_TAB [0:31] = '{
    17'd0,
    half_period(262),  half_period(294),  half_period(330),  half_period(349),
    half_period(392),  half_period(440),  half_period(494),
    half_period(523),  half_period(587),  half_period(659),  half_period(698),
    half_period(784),  half_period(880),  half_period(988),
    half_period(1046), half_period(1175), half_period(1318), half_period(1397),
    half_period(1568), half_period(1760), half_period(1976),
    17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0
  };

  state_t      state_q, state_d;
  logic [7:0]  tone_q, tone_d;
  logic [7:0]  tone_prev_q, tone_prev_d;
  logic        en_prev_q, en_prev_d;
  logic        beep_q, beep_d;
  logic        playing_q, playing_d;
  logic        tone_err_q, tone_err_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;

  logic        change;
  logic        is_note;
  logic        is_bad;
  logic        enter_note;
  logic [4:0]  note_idx;
  logic [16:0] hp_m1;

  assign change   = (tone_q != tone_prev_q);
  assign is_note  = (tone_q != 8'd0) && (tone_q <= TONE_MAX);
  assign is_bad   = (tone_q > TONE_STOP);
  assign note_idx = is_note ? tone_q[4:0] : 5'd0;
  assign hp_m1    = HP_TAB[note_idx] - 17'd1;

  always_comb begin
    tone_d      = music_tone;
    tone_prev_d = tone_q;
    en_prev_d   = beep_en;
    state_d     = state_q;
    beep_d      = beep_q;
    cnt_d       = cnt_q;
    ms_cnt_d    = ms_cnt_q;
    enter_note  = 1'b0;

    // Priority: enable, then a tone change, then the per-state behaviour.
    if (!beep_en) begin
      state_d = IDLE;
    end else if (change && !is_note) begin
      state_d = IDLE;
    end else if (change) begin
      enter_note = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!en_prev_q && is_note) begin
            enter_note = 1'b1;
          end
        end
        GAP: begin
          if (clk_1ms) begin
            ms_cnt_d = ms_cnt_q + 16'd1;
            if (ms_cnt_d == GAP_LIM) begin
              state_d = PLAY;
              cnt_d   = 17'd0;
              beep_d  = 1'b0;
            end
          end
        end
        PLAY: begin
          if (cnt_q == hp_m1) begin
            cnt_d  = 17'd0;
            beep_d = ~beep_q;
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (enter_note) begin
      state_d  = NO_GAP ? PLAY : GAP;
      cnt_d    = 17'd0;
      ms_cnt_d = 16'd0;
      beep_d   = 1'b0;
    end

    if (state_d == IDLE) begin
      beep_d   = 1'b0;
      cnt_d    = 17'd0;
      ms_cnt_d = 16'd0;
    end

    playing_d  = (state_d == PLAY);
    tone_err_d = change && is_bad;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      tone_q      <= TONE_STOP;
      tone_prev_q <= TONE_STOP;
      en_prev_q   <= 1'b0;
      beep_q      <= 1'b0;
      playing_q   <= 1'b0;
      tone_err_q  <= 1'b0;
      cnt_q       <= 17'd0;
      ms_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      tone_q      <= tone_d;
      tone_prev_q <= tone_prev_d;
      en_prev_q   <= en_prev_d;
      beep_q      <= beep_d;
      playing_q   <= playing_d;
      tone_err_q  <= tone_err_d;
      cnt_q       <= cnt_d;
      ms_cnt_q    <= ms_cnt_d;
    end
  end

  assign beep     = beep_q;
  assign playing  = playing_q;
  assign tone_err = tone_err_q;

endmodule
